// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding
// and default sizing for the FIFO depth and the oversampling tick divider.
package uart_pkg;

   localparam int DEF_DEPTH    = 8;
   localparam int DEF_TICK_DIV = 326;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered full/empty/count and overflow pulse.
// Ports: clk, reset (sync, active high), push/wr_data, pop/data (head byte),
//        full, empty, count, overflow (one cycle after a dropped push).
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               wr_data,
   input  logic                     pop,
   output logic [7:0]               data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_ovf;
   logic [CW-1:0] w_count_nx;
   logic          w_push_ok;
   logic          w_pop_ok;

   // Acceptance uses the registered flags, so a push into a full FIFO is
   // dropped even when a pop frees a slot on the same edge.
   assign w_push_ok = push & ~r_full;
   assign w_pop_ok  = pop & ~r_empty;

   always_comb begin
      w_count_nx = r_count;
      if (w_push_ok & ~w_pop_ok)
         w_count_nx = r_count + 1'b1;
      else if (~w_push_ok & w_pop_ok)
         w_count_nx = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nx;
         r_full  <= (w_count_nx == CW'(DEPTH));
         r_empty <= (w_count_nx == '0);
         r_ovf   <= push & r_full;
      end
   end

   assign data     = r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;
   assign count    = r_count;
   assign overflow = r_ovf;

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds bytes from a FIFO to a UART transmitter with a req/done handshake,
// and generates the free-running oversampling tick.
// Ports: clk, reset, wr_data/wr_en (enqueue), full/empty/count/overflow,
//        tx_data/tx_transmission (to transmitter), tx_done (from it), s_tick.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               tx_data,
   output logic                     tx_transmission,
   input  logic                     tx_done,
   output logic                     s_tick
);

   localparam int DW = $clog2(TICK_DIV);

   logic [DW-1:0] r_div;
   logic          r_tick;
   state_t        r_state;
   logic [7:0]    r_tx_data;
   logic          r_tx_req;
   logic [7:0]    w_head;
   logic          w_empty;
   logic          w_pop;

   uart_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (wr_en),
      .wr_data  (wr_data),
      .pop      (w_pop),
      .data     (w_head),
      .full     (full),
      .empty    (w_empty),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if (r_div == DW'(TICK_DIV - 1)) begin
         r_div  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_div  <= r_div + 1'b1;
         r_tick <= 1'b0;
      end
   end

   // The pop is taken on the same edge that latches the head into tx_data.
   assign w_pop = (r_state == IDLE) & ~w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_tx_data <= 8'h00;
         r_tx_req  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_tx_data <= w_head;
                  r_tx_req  <= 1'b1;
                  r_state   <= SEND;
               end
            end
            SEND: begin
               if (tx_done) begin
                  r_tx_req <= 1'b0;
                  r_state  <= RELEASE;
               end
            end
            RELEASE: begin
               if (!tx_done)
                  r_state <= IDLE;
            end
            default: begin
               r_state  <= IDLE;
               r_tx_req <= 1'b0;
            end
         endcase
      end
   end

   assign empty           = w_empty;
   assign tx_data         = r_tx_data;
   assign tx_transmission = r_tx_req;
   assign s_tick          = r_tick;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed vector table, overflow,
// reset and tick sequences, and randomized traffic against a queue model.
module tb_uart_tx_feeder;

   localparam int DEPTH = 8;
   localparam int TDIV  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       tx_done;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] tx_data;
   logic       tx_transmission;
   logic       s_tick;

   int n_chk = 0;
   int n_pass = 0;

   uart_tx_feeder #(
      .DEPTH    (DEPTH),
      .TICK_DIV (TDIV)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .wr_data         (wr_data),
      .wr_en           (wr_en),
      .full            (full),
      .empty           (empty),
      .count           (count),
      .overflow        (overflow),
      .tx_data         (tx_data),
      .tx_transmission (tx_transmission),
      .tx_done         (tx_done),
      .s_tick          (s_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [7:0] wd;
      logic       done;
      logic       txr;
      logic [7:0] txd;
      int         cnt;
      logic       emp;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] got [$];
      logic [7:0] q [$];
      int         link;
      int         cyc;
      logic       prev;
      logic       e_txr;
      logic [7:0] e_data;
      logic       e_ovf;
      int         sz;
      logic [16:0] e_vec;
      logic [16:0] a_vec;

      tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b1};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b1};
      tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
      tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1, 1'b0};
      tbl[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 2, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 2, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 2, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 0, 1'b1};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 0, 1'b1};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 0, 1'b1};

      // reset values
      do_reset();
      chk("rst full", full, 0);
      chk("rst empty", empty, 1);
      chk("rst count", count, 0);
      chk("rst overflow", overflow, 0);
      chk("rst tx_data", tx_data, 0);
      chk("rst tx_req", tx_transmission, 0);
      chk("rst s_tick", s_tick, 0);

      // tick divider: first strobe on the 4th edge after release
      for (int n = 1; n <= 12; n++) begin
         step();
         chk($sformatf("s_tick edge%0d", n), s_tick, (n % TDIV == 0) ? 1 : 0);
      end

      // directed vector table
      do_reset();
      for (int i = 0; i < 18; i++) begin
         wr_en   = tbl[i].we;
         wr_data = tbl[i].wd;
         tx_done = tbl[i].done;
         step();
         chk($sformatf("vec%0d tx_req", i), tx_transmission, tbl[i].txr);
         chk($sformatf("vec%0d tx_data", i), tx_data, tbl[i].txd);
         chk($sformatf("vec%0d count", i), count, tbl[i].cnt);
         chk($sformatf("vec%0d empty", i), empty, tbl[i].emp);
      end
      wr_en = 1'b0;
      tx_done = 1'b0;

      // overflow with FSM held in SEND, then drop during a pop cycle
      do_reset();
      wr_en = 1'b1;
      wr_data = 8'hF0;
      step();
      wr_en = 1'b0;
      step();
      chk("ovf send", tx_transmission, 1);
      chk("ovf send data", tx_data, 8'hF0);
      for (int k = 1; k <= 9; k++) begin
         wr_en = 1'b1;
         wr_data = 8'(k);
         step();
         if (k == 8) begin
            chk("ovf full8", full, 1);
            chk("ovf no ovf8", overflow, 0);
         end
      end
      chk("ovf pulse", overflow, 1);
      chk("ovf count", count, 8);
      chk("ovf full", full, 1);
      wr_en = 1'b0;
      step();
      chk("ovf one cycle", overflow, 0);
      chk("ovf count hold", count, 8);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      wr_en = 1'b1;
      wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      chk("popdrop count", count, 7);
      chk("popdrop overflow", overflow, 1);
      chk("popdrop full", full, 0);
      chk("popdrop tx_req", tx_transmission, 1);
      chk("popdrop tx_data", tx_data, 8'h01);
      got.delete();
      got.push_back(tx_data);
      prev = tx_transmission;
      for (int c = 0; c < 60; c++) begin
         tx_done = tx_transmission;
         step();
         if (tx_transmission && !prev)
            got.push_back(tx_data);
         prev = tx_transmission;
      end
      tx_done = 1'b0;
      chk("drain bytes", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++)
         chk($sformatf("drain byte%0d", i), got[i], i + 1);
      chk("drain empty", empty, 1);
      chk("drain count", count, 0);

      // reset in the middle of SEND
      do_reset();
      wr_en = 1'b1;
      wr_data = 8'h44;
      step();
      wr_en = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'b1;
         wr_data = 8'h50 + 8'(k);
         step();
      end
      wr_en = 1'b0;
      chk("midrst pre count", count, 3);
      chk("midrst pre tx_req", tx_transmission, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst tx_req", tx_transmission, 0);
      chk("midrst tx_data", tx_data, 0);
      chk("midrst empty", empty, 1);
      chk("midrst count", count, 0);
      chk("midrst full", full, 0);
      step();
      step();
      chk("midrst no stale pop", tx_transmission, 0);

      // randomized traffic against a queue model of the spec rules
      do_reset();
      q.delete();
      link   = 0;
      cyc    = 0;
      e_txr  = 1'b0;
      e_data = 8'h00;
      for (int c = 0; c < 800; c++) begin
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_data = 8'($urandom);
         tx_done = ($urandom_range(0, 3) == 0);
         sz = q.size();
         e_ovf = wr_en && (sz == DEPTH);
         if (link == 0 && sz > 0) begin
            e_data = q.pop_front();
            e_txr  = 1'b1;
            link   = 1;
         end else if (link == 1 && tx_done) begin
            e_txr = 1'b0;
            link  = 2;
         end else if (link == 2 && !tx_done) begin
            link = 0;
         end
         if (wr_en && sz < DEPTH)
            q.push_back(wr_data);
         cyc++;
         step();
         e_vec = {q.size() == DEPTH, q.size() == 0, e_ovf, e_txr,
                  cyc % TDIV == 0, 4'(q.size()), e_data};
         a_vec = {full, empty, overflow, tx_transmission,
                  s_tick, count, tx_data};
         chk($sformatf("rand cyc%0d", c), int'(a_vec), int'(e_vec));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
